// File: rtl/ddr3_device_model_if.sv
// DDR3 command/control pin bundle between the memory controller and the device model.
// Carries CKE, CS#, RAS#/CAS#/WE#, bank and address, data mask, ODT and the
// differential clock. The bidirectional DQ/DQS pins stay on the model's port
// list, because they need real tristate nets.
interface ddr3_device_model_if #(
    parameter int unsigned ROW_WIDTH = 15,
    parameter int unsigned BA_WIDTH  = 3,
    parameter int unsigned DM_WIDTH  = 4
);
    logic                 cke;
    logic                 cs_n;
    logic                 ras_n;
    logic                 cas_n;
    logic                 we_n;
    logic [BA_WIDTH-1:0]  ba;
    logic [ROW_WIDTH-1:0] addr;
    logic [DM_WIDTH-1:0]  dm;
    logic                 odt;
    logic                 ck_p;
    logic                 ck_n;

    modport master (output cke, cs_n, ras_n, cas_n, we_n, ba, addr, dm, odt, ck_p, ck_n);
    modport slave  (input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, dm, odt, ck_p, ck_n);
endinterface

// File: rtl/ddr3_device_model.sv
// Cycle-based single-rank x32 DDR3 device model. It uses SDR beats: one beat per clock edge.
// Ports: clock/reset (sync, active-high), ddr3_reset_n (device reset, sampled
// synchronously), ddr3 (command/control bundle), ddr3_dq / ddr3_dqs_p / ddr3_dqs_n
// (tristate data and read strobe), init_calib_complete, err (sticky violation).
// Timing: a command is sampled at edge T. Write beat b is sampled at edge T+CWL+b.
// Read beat b is driven out of a register loaded at edge T+CL+b.
module ddr3_device_model #(
    parameter int unsigned ROW_WIDTH    = 15,
    parameter int unsigned BA_WIDTH     = 3,
    parameter int unsigned COL_WIDTH    = 10,
    parameter int unsigned DQ_WIDTH     = 32,
    parameter int unsigned DM_WIDTH     = 4,
    parameter int unsigned DQS_WIDTH    = 4,
    parameter int unsigned MEM_ROW_BITS = 2,
    parameter int unsigned CL           = 5,
    parameter int unsigned CWL          = 5,
    parameter int unsigned CALIB_CYCLES = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ddr3_reset_n,
    ddr3_device_model_if.slave   ddr3,
    inout  wire  [DQ_WIDTH-1:0]  ddr3_dq,
    inout  wire  [DQS_WIDTH-1:0] ddr3_dqs_p,
    inout  wire  [DQS_WIDTH-1:0] ddr3_dqs_n,
    output logic                 init_calib_complete,
    output logic                 err
);
    localparam int unsigned NB        = 1 << BA_WIDTH;
    localparam int unsigned BASE_W    = BA_WIDTH + MEM_ROW_BITS + COL_WIDTH - 3;
    localparam int unsigned IDX_W     = BASE_W + 3;
    localparam int unsigned DEPTH     = 1 << IDX_W;
    localparam int unsigned CNT_W     = $clog2(CALIB_CYCLES + 1);
    localparam int          DIFF      = int'(CL) - int'(CWL);
    // Saturation value of the access-gap counter. It is large enough that a saturated
    // gap can never look like a spacing or window-overlap conflict.
    localparam int unsigned SINCE_MAX = (CL > CWL) ? (8 + CL - CWL) : (8 + CWL - CL);
    localparam int unsigned SINCE_W   = $clog2(SINCE_MAX + 1);

    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_REF = 3'b001;

    logic                            rst_c;
    logic                            cmd_v_c;
    logic [2:0]                      cmd_c;
    logic [BASE_W-1:0]               base_c;
    logic                            rw_close_c, rd_ovl_c, wr_ovl_c;
    int                              rd_slack, wr_slack;
    logic                            rd_go_c, wr_go_c;
    logic [IDX_W-1:0]                rd_idx_c, wr_idx_c;

    logic [CNT_W-1:0]                calib_cnt_q, calib_cnt_d;
    logic                            calib_done_q, calib_done_d;
    logic                            err_q, err_d;
    logic [NB-1:0]                   bank_open_q, bank_open_d;
    logic [NB-1:0][ROW_WIDTH-1:0]    bank_row_q, bank_row_d;
    logic [SINCE_W-1:0]              since_q, since_d;
    logic                            last_wr_q, last_wr_d;
    logic [CL-1:0]                   rd_tok_q, rd_tok_d;
    logic [CL-1:0][BASE_W-1:0]       rd_pipe_q, rd_pipe_d;
    logic                            rd_run_q, rd_run_d;
    logic [BASE_W-1:0]               rd_base_q, rd_base_d;
    logic [2:0]                      rd_beat_q, rd_beat_d;
    logic                            rd_oe_q, rd_oe_d;
    logic [CWL-1:0]                  wr_tok_q, wr_tok_d;
    logic [CWL-1:0][BASE_W-1:0]      wr_pipe_q, wr_pipe_d;
    logic                            wr_run_q, wr_run_d;
    logic [BASE_W-1:0]               wr_base_q, wr_base_d;
    logic [2:0]                      wr_beat_q, wr_beat_d;
    logic [DQ_WIDTH-1:0]             rd_data_q;
    logic [DQ_WIDTH-1:0]             mem_q [DEPTH];

    assign rst_c   = reset | ~ddr3_reset_n;
    assign cmd_v_c = ddr3.cke & ~ddr3.cs_n;
    assign cmd_c   = {ddr3.ras_n, ddr3.cas_n, ddr3.we_n};

    // Next-state: calibration, command decode, latency pipelines and burst runners.
    always_comb begin
        calib_cnt_d  = calib_cnt_q;
        calib_done_d = calib_done_q;
        err_d        = err_q;
        bank_open_d  = bank_open_q;
        bank_row_d   = bank_row_q;
        since_d      = (since_q == SINCE_W'(SINCE_MAX)) ? since_q : since_q + SINCE_W'(1);
        last_wr_d    = last_wr_q;
        rd_run_d     = rd_run_q;
        rd_base_d    = rd_base_q;
        rd_beat_d    = rd_beat_q;
        wr_run_d     = wr_run_q;
        wr_base_d    = wr_base_q;
        wr_beat_d    = wr_beat_q;

        if (ddr3.cke && calib_cnt_q != CNT_W'(CALIB_CYCLES))
            calib_cnt_d = calib_cnt_q + CNT_W'(1);
        calib_done_d = calib_done_q | (calib_cnt_d == CNT_W'(CALIB_CYCLES));

        base_c     = {ddr3.ba, bank_row_q[ddr3.ba][MEM_ROW_BITS-1:0], ddr3.addr[COL_WIDTH-1:3]};
        rw_close_c = since_q < SINCE_W'(8);
        // Distance between the new burst window and the last opposite-direction window.
        rd_slack   = DIFF + int'(since_q);
        wr_slack   = int'(since_q) - DIFF;
        rd_ovl_c   = last_wr_q && (rd_slack > -8) && (rd_slack < 8);
        wr_ovl_c   = !last_wr_q && (wr_slack > -8) && (wr_slack < 8);

        // Latency delay lines: a token enters stage 0 on an accepted command.
        for (int k = int'(CL) - 1; k > 0; k--) begin
            rd_tok_d[k]  = rd_tok_q[k-1];
            rd_pipe_d[k] = rd_pipe_q[k-1];
        end
        rd_tok_d[0]  = 1'b0;
        rd_pipe_d[0] = base_c;
        for (int k = int'(CWL) - 1; k > 0; k--) begin
            wr_tok_d[k]  = wr_tok_q[k-1];
            wr_pipe_d[k] = wr_pipe_q[k-1];
        end
        wr_tok_d[0]  = 1'b0;
        wr_pipe_d[0] = base_c;

        // A pipeline head performs beat 0 itself. The runner then covers beats 1..7.
        rd_go_c  = ~rst_c & (rd_tok_q[CL-1] | rd_run_q);
        rd_idx_c = rd_tok_q[CL-1] ? {rd_pipe_q[CL-1], 3'd0} : {rd_base_q, rd_beat_q};
        rd_oe_d  = rd_tok_q[CL-1] | rd_run_q;
        if (rd_tok_q[CL-1]) begin
            rd_run_d  = 1'b1;
            rd_base_d = rd_pipe_q[CL-1];
            rd_beat_d = 3'd1;
        end else if (rd_run_q) begin
            rd_run_d  = (rd_beat_q != 3'd7);
            rd_beat_d = rd_beat_q + 3'd1;
        end
        wr_go_c  = ~rst_c & (wr_tok_q[CWL-1] | wr_run_q);
        wr_idx_c = wr_tok_q[CWL-1] ? {wr_pipe_q[CWL-1], 3'd0} : {wr_base_q, wr_beat_q};
        if (wr_tok_q[CWL-1]) begin
            wr_run_d  = 1'b1;
            wr_base_d = wr_pipe_q[CWL-1];
            wr_beat_d = 3'd1;
        end else if (wr_run_q) begin
            wr_run_d  = (wr_beat_q != 3'd7);
            wr_beat_d = wr_beat_q + 3'd1;
        end

        // Command decode. A violating command sets err and is otherwise ignored.
        if (cmd_v_c) begin
            case (cmd_c)
                CMD_ACT: begin
                    if (bank_open_q[ddr3.ba]) begin
                        err_d = 1'b1;
                    end else begin
                        bank_open_d[ddr3.ba] = 1'b1;
                        bank_row_d[ddr3.ba]  = ddr3.addr;
                    end
                end
                CMD_PRE: begin
                    if (ddr3.addr[10]) bank_open_d = '0;
                    else               bank_open_d[ddr3.ba] = 1'b0;
                end
                CMD_RD: begin
                    if (!bank_open_q[ddr3.ba] || rw_close_c || rd_ovl_c) begin
                        err_d = 1'b1;
                    end else begin
                        rd_tok_d[0] = 1'b1;
                        since_d     = SINCE_W'(1);
                        last_wr_d   = 1'b0;
                    end
                end
                CMD_WR: begin
                    if (!bank_open_q[ddr3.ba] || rw_close_c || wr_ovl_c) begin
                        err_d = 1'b1;
                    end else begin
                        wr_tok_d[0] = 1'b1;
                        since_d     = SINCE_W'(1);
                        last_wr_d   = 1'b1;
                    end
                end
                CMD_REF: begin
                    if (|bank_open_q) err_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State register. Reset aborts bursts but leaves the storage array untouched.
    always_ff @(posedge clock) begin
        if (rst_c) begin
            calib_cnt_q  <= '0;
            calib_done_q <= 1'b0;
            err_q        <= 1'b0;
            bank_open_q  <= '0;
            bank_row_q   <= '0;
            since_q      <= SINCE_W'(SINCE_MAX);
            last_wr_q    <= 1'b0;
            rd_tok_q     <= '0;
            rd_pipe_q    <= '0;
            rd_run_q     <= 1'b0;
            rd_base_q    <= '0;
            rd_beat_q    <= '0;
            rd_oe_q      <= 1'b0;
            wr_tok_q     <= '0;
            wr_pipe_q    <= '0;
            wr_run_q     <= 1'b0;
            wr_base_q    <= '0;
            wr_beat_q    <= '0;
        end else begin
            calib_cnt_q  <= calib_cnt_d;
            calib_done_q <= calib_done_d;
            err_q        <= err_d;
            bank_open_q  <= bank_open_d;
            bank_row_q   <= bank_row_d;
            since_q      <= since_d;
            last_wr_q    <= last_wr_d;
            rd_tok_q     <= rd_tok_d;
            rd_pipe_q    <= rd_pipe_d;
            rd_run_q     <= rd_run_d;
            rd_base_q    <= rd_base_d;
            rd_beat_q    <= rd_beat_d;
            rd_oe_q      <= rd_oe_d;
            wr_tok_q     <= wr_tok_d;
            wr_pipe_q    <= wr_pipe_d;
            wr_run_q     <= wr_run_d;
            wr_base_q    <= wr_base_d;
            wr_beat_q    <= wr_beat_d;
        end
    end

    // Burst storage with a byte-masked write port and a registered read port.
    always_ff @(posedge clock) begin
        if (rd_go_c) rd_data_q <= mem_q[rd_idx_c];
        if (wr_go_c) begin
            for (int i = 0; i < int'(DM_WIDTH); i++) begin
                if (!ddr3.dm[i]) mem_q[wr_idx_c][8*i +: 8] <= ddr3_dq[8*i +: 8];
            end
        end
    end

    assign ddr3_dq             = rd_oe_q ? rd_data_q : {DQ_WIDTH{1'bz}};
    assign ddr3_dqs_p          = rd_oe_q ? {DQS_WIDTH{1'b1}} : {DQS_WIDTH{1'bz}};
    assign ddr3_dqs_n          = rd_oe_q ? {DQS_WIDTH{1'b0}} : {DQS_WIDTH{1'bz}};
    assign init_calib_complete = calib_done_q;
    assign err                 = err_q;

    // These pins and bits are accepted but have no effect on the model.
    logic unused_ok;
    assign unused_ok = ^{ddr3.odt, ddr3.ck_p, ddr3.ck_n, ddr3_dqs_p, ddr3_dqs_n, bank_row_q};
endmodule

// File: tb/tb_ddr3_device_model.sv
// Directed bench for ddr3_device_model. It covers calibration, write/read bursts,
// byte masking, storage retention across reset, and the protocol violations.
// Outside an expected read window the bench drives a known pattern on DQ and
// zero on DQS_P. If the model drives the bus at that time, the read-back value
// comes out wrong.
module tb_ddr3_device_model;
    localparam int CL    = 5;
    localparam int CWL   = 5;
    localparam int CALIB = 1000;
    localparam logic [31:0] PROBE = 32'h5A5A_5A5A;
    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_REF = 3'b001;

    logic        clock = 1'b0;
    logic        reset;
    logic        ddr3_reset_n;
    logic        init_calib_complete;
    logic        err;
    wire  [31:0] ddr3_dq;
    wire  [3:0]  ddr3_dqs_p;
    wire  [3:0]  ddr3_dqs_n;
    logic [31:0] tb_dq;
    logic        tb_dq_en;
    logic        tb_dqs_en;
    logic [31:0] wbeat [8];
    logic [3:0]  wmask [8];
    logic [31:0] rexp  [8];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    assign ddr3_dq    = tb_dq_en  ? tb_dq : 32'bz;
    assign ddr3_dqs_p = tb_dqs_en ? 4'h0  : 4'bz;

    ddr3_device_model_if bus_if ();

    ddr3_device_model dut (
        .clock               (clock),
        .reset               (reset),
        .ddr3_reset_n        (ddr3_reset_n),
        .ddr3                (bus_if),
        .ddr3_dq             (ddr3_dq),
        .ddr3_dqs_p          (ddr3_dqs_p),
        .ddr3_dqs_n          (ddr3_dqs_n),
        .init_calib_complete (init_calib_complete),
        .err                 (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic probe_on();
        tb_dq     = PROBE;
        tb_dq_en  = 1'b1;
        tb_dqs_en = 1'b1;
        #1;
    endtask

    task automatic probe_off();
        tb_dq_en  = 1'b0;
        tb_dqs_en = 1'b0;
    endtask

    // Presents one command for exactly one rising edge and then returns to NOP.
    task automatic cmd(input logic [2:0] c, input logic [2:0] ba, input logic [14:0] addr);
        bus_if.cs_n = 1'b0;
        {bus_if.ras_n, bus_if.cas_n, bus_if.we_n} = c;
        bus_if.ba   = ba;
        bus_if.addr = addr;
        step();
        bus_if.cs_n = 1'b1;
        {bus_if.ras_n, bus_if.cas_n, bus_if.we_n} = C_NOP;
    endtask

    task automatic do_write(input logic [2:0] ba, input logic [14:0] col);
        cmd(C_WR, ba, col);
        for (int k = 0; k < CWL - 1; k++) step();
        tb_dq_en = 1'b1;
        for (int b = 0; b < 8; b++) begin
            tb_dq     = wbeat[b];
            bus_if.dm = wmask[b];
            step();
        end
        bus_if.dm = 4'h0;
        probe_on();
    endtask

    task automatic do_read(input string tag, input logic [2:0] ba, input logic [14:0] col);
        cmd(C_RD, ba, col);
        for (int k = 1; k < CL; k++) step();
        check($sformatf("%s pre dq", tag), ddr3_dq, PROBE);
        check($sformatf("%s pre dqs_p", tag), 32'(ddr3_dqs_p), 32'h0);
        probe_off();
        step();
        for (int b = 0; b < 8; b++) begin
            check($sformatf("%s beat%0d", tag, b), ddr3_dq, rexp[b]);
            check($sformatf("%s dqs_p%0d", tag, b), 32'(ddr3_dqs_p), 32'hF);
            check($sformatf("%s dqs_n%0d", tag, b), 32'(ddr3_dqs_n), 32'h0);
            if (b < 7) step();
        end
        step();
        probe_on();
        check($sformatf("%s post dq", tag), ddr3_dq, PROBE);
        check($sformatf("%s post dqs_p", tag), 32'(ddr3_dqs_p), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        ddr3_reset_n = 1'b1;
        bus_if.cke   = 1'b0;
        bus_if.cs_n  = 1'b1;
        {bus_if.ras_n, bus_if.cas_n, bus_if.we_n} = C_NOP;
        bus_if.ba    = 3'd0;
        bus_if.addr  = 15'd0;
        bus_if.dm    = 4'h0;
        bus_if.odt   = 1'b0;
        bus_if.ck_p  = 1'b0;
        bus_if.ck_n  = 1'b1;
        probe_on();
        repeat (3) step();

        // Reset state
        check("rst calib", 32'(init_calib_complete), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst dq", ddr3_dq, PROBE);
        check("rst dqs_p", 32'(ddr3_dqs_p), 32'h0);

        // Calibration count from reset release
        reset      = 1'b0;
        bus_if.cke = 1'b1;
        for (int k = 1; k <= CALIB; k++) begin
            step();
            if (k == CALIB - 1) check("calib at 999", 32'(init_calib_complete), 32'd0);
            if (k == CALIB)     check("calib at 1000", 32'(init_calib_complete), 32'd1);
        end
        reset = 1'b1;
        step();
        check("calib after reset", 32'(init_calib_complete), 32'd0);
        reset = 1'b0;
        step();

        // Basic write then read burst
        cmd(C_ACT, 3'd2, 15'h0005);
        step();
        for (int i = 0; i < 8; i++) begin
            wbeat[i] = 32'h1111_1111 * 32'(i + 1);
            wmask[i] = 4'h0;
            rexp[i]  = wbeat[i];
        end
        do_write(3'd2, 15'h0010);
        step();
        do_read("rd_basic", 3'd2, 15'h0010);
        check("err after basic", 32'(err), 32'd0);

        // Byte mask: clear the burst, then do a masked write to beat 0 only
        for (int i = 0; i < 8; i++) begin
            wbeat[i] = 32'h0;
            wmask[i] = 4'h0;
        end
        do_write(3'd2, 15'h0020);
        step();
        wbeat[0] = 32'hAABB_CCDD;
        wmask[0] = 4'b0101;
        for (int i = 1; i < 8; i++) begin
            wbeat[i] = 32'hFFFF_FFFF;
            wmask[i] = 4'hF;
        end
        do_write(3'd2, 15'h0020);
        step();
        rexp[0] = 32'hAA00_CC00;
        for (int i = 1; i < 8; i++) rexp[i] = 32'h0;
        do_read("rd_mask", 3'd2, 15'h0020);
        check("err after mask", 32'(err), 32'd0);

        // READ to closed bank 3
        cmd(C_RD, 3'd3, 15'h0010);
        check("err closed bank", 32'(err), 32'd1);
        for (int k = 0; k < CL + 8; k++) begin
            step();
            check($sformatf("closed dq c%0d", k), ddr3_dq, PROBE);
        end
        reset = 1'b1;
        step();
        check("err cleared", 32'(err), 32'd0);
        reset = 1'b0;
        step();

        // Storage survives reset; the bank must be reopened
        cmd(C_ACT, 3'd2, 15'h0005);
        step();
        for (int i = 0; i < 8; i++) rexp[i] = 32'h1111_1111 * 32'(i + 1);
        do_read("rd_retained", 3'd2, 15'h0010);
        check("err after retained", 32'(err), 32'd0);

        // Second READ 4 cycles after the first is ignored
        cmd(C_RD, 3'd2, 15'h0010);
        repeat (3) step();
        cmd(C_RD, 3'd2, 15'h0020);
        probe_off();
        step();
        for (int b = 0; b < 8; b++) begin
            check($sformatf("dbl beat%0d", b), ddr3_dq, rexp[b]);
            if (b < 7) step();
        end
        step();
        probe_on();
        check("dbl post dq", ddr3_dq, PROBE);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("dbl tail dq%0d", k), ddr3_dq, PROBE);
        end
        check("err double read", 32'(err), 32'd1);

        // Precharge-all, refresh and reopen
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("err cleared 2", 32'(err), 32'd0);
        cmd(C_ACT, 3'd0, 15'h0001);
        cmd(C_ACT, 3'd7, 15'h0002);
        cmd(C_PRE, 3'd0, 15'h0400);
        cmd(C_REF, 3'd0, 15'h0000);
        cmd(C_ACT, 3'd0, 15'h0003);
        step();
        check("err pre all", 32'(err), 32'd0);
        cmd(C_ACT, 3'd0, 15'h0003);
        check("err act open", 32'(err), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
